// File: rtl/alarm_sequencer_pkg.sv
// Shared clock definitions: time field widths and alarm sequencer state encoding.
package alarm_sequencer_pkg;

    localparam int unsigned HourW = 5;
    localparam int unsigned MinW  = 6;

    typedef enum logic [1:0] {
        StIdle,
        StRinging,
        StSnooze
    } alarm_state_e;

endpackage

// File: rtl/alarm_time_match.sv
// Compares current time with alarm time and emits a one-clk trigger on the
// rising edge of the match while the alarm is armed.
module alarm_time_match
    import alarm_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [HourW-1:0] cur_hour,
    input  logic [MinW-1:0]  cur_min,
    input  logic [HourW-1:0] alm_hour,
    input  logic [MinW-1:0]  alm_min,
    input  logic            alarm_en,
    output logic            trigger
);

    logic match;
    logic match_q;

    assign match   = (cur_hour == alm_hour) && (cur_min == alm_min);
    assign trigger = match && !match_q && alarm_en;

    // Reset to 1 so a time already equal to the alarm at release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b1;
        end else begin
            match_q <= match;
        end
    end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm event sequencer: rings on time match, supports limited snoozes,
// auto-stops after the ring duration.
module alarm_sequencer
    import alarm_sequencer_pkg::*;
#(
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned SNOOZE_SECONDS = 300,
    parameter int unsigned MAX_SNOOZE     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_1hz,
    input  logic [HourW-1:0] cur_hour,
    input  logic [MinW-1:0]  cur_min,
    input  logic [HourW-1:0] alm_hour,
    input  logic [MinW-1:0]  alm_min,
    input  logic             alarm_en,
    input  logic             stop_btn,
    input  logic             snooze_btn,
    output logic             alarm_on,
    output logic             snoozing,
    output logic [1:0]       snooze_used
);

    localparam int unsigned RingW = $clog2(RING_SECONDS + 1);
    localparam int unsigned SnzW  = $clog2(SNOOZE_SECONDS + 1);

    localparam logic [RingW-1:0] RingLast = RingW'(RING_SECONDS - 1);
    localparam logic [SnzW-1:0]  SnzInit  = SnzW'(SNOOZE_SECONDS);
    localparam logic [SnzW-1:0]  SnzLast  = SnzW'(1);
    localparam logic [1:0]       MaxSnz   = 2'(MAX_SNOOZE);

    logic trigger;

    alarm_state_e     state_q, state_d;
    logic [RingW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SnzW-1:0]  snz_cnt_q, snz_cnt_d;
    logic [1:0]       snooze_used_q, snooze_used_d;
    logic             alarm_on_q, alarm_on_d;
    logic             snoozing_q, snoozing_d;

    alarm_time_match u_match (
        .clk      (clk),
        .rst_n    (rst_n),
        .cur_hour (cur_hour),
        .cur_min  (cur_min),
        .alm_hour (alm_hour),
        .alm_min  (alm_min),
        .alarm_en (alarm_en),
        .trigger  (trigger)
    );

    // Branch order encodes event priority: disarm > stop > snooze > tick expiry.
    always_comb begin
        state_d       = state_q;
        ring_cnt_d    = ring_cnt_q;
        snz_cnt_d     = snz_cnt_q;
        snooze_used_d = snooze_used_q;

        if (!alarm_en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (trigger) begin
                        state_d       = StRinging;
                        ring_cnt_d    = '0;
                        snooze_used_d = '0;
                    end
                end
                StRinging: begin
                    if (stop_btn) begin
                        state_d = StIdle;
                    end else if (snooze_btn) begin
                        if (snooze_used_q < MaxSnz) begin
                            state_d       = StSnooze;
                            snz_cnt_d     = SnzInit;
                            snooze_used_d = snooze_used_q + 2'd1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else if (tick_1hz) begin
                        if (ring_cnt_q == RingLast) begin
                            state_d = StIdle;
                        end else begin
                            ring_cnt_d = ring_cnt_q + RingW'(1);
                        end
                    end
                end
                StSnooze: begin
                    if (stop_btn) begin
                        state_d = StIdle;
                    end else if (tick_1hz) begin
                        if (snz_cnt_q == SnzLast) begin
                            state_d    = StRinging;
                            ring_cnt_d = '0;
                        end else begin
                            snz_cnt_d = snz_cnt_q - SnzW'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        alarm_on_d = (state_d == StRinging);
        snoozing_d = (state_d == StSnooze);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ring_cnt_q    <= '0;
            snz_cnt_q     <= '0;
            snooze_used_q <= '0;
            alarm_on_q    <= 1'b0;
            snoozing_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ring_cnt_q    <= ring_cnt_d;
            snz_cnt_q     <= snz_cnt_d;
            snooze_used_q <= snooze_used_d;
            alarm_on_q    <= alarm_on_d;
            snoozing_q    <= snoozing_d;
        end
    end

    assign alarm_on    = alarm_on_q;
    assign snoozing    = snoozing_q;
    assign snooze_used = snooze_used_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed scoreboard bench for alarm_sequencer with short ring/snooze timings.
module tb_alarm_sequencer;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [4:0] alm_hour;
    logic [5:0] alm_min;
    logic       alarm_en;
    logic       stop_btn;
    logic       snooze_btn;
    logic       alarm_on;
    logic       snoozing;
    logic [1:0] snooze_used;

    typedef struct {
        string      tag;
        logic       ao;
        logic       sn;
        logic [1:0] su;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    alarm_sequencer #(
        .RING_SECONDS   (5),
        .SNOOZE_SECONDS (3),
        .MAX_SNOOZE     (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1hz    (tick_1hz),
        .cur_hour    (cur_hour),
        .cur_min     (cur_min),
        .alm_hour    (alm_hour),
        .alm_min     (alm_min),
        .alarm_en    (alarm_en),
        .stop_btn    (stop_btn),
        .snooze_btn  (snooze_btn),
        .alarm_on    (alarm_on),
        .snoozing    (snoozing),
        .snooze_used (snooze_used)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Queue the expectation for the current inputs, clock once, then compare.
    task automatic apply(input string tag, input logic ao, input logic sn, input logic [1:0] su);
        exp_t e;
        exp_t got;
        e.tag = tag;
        e.ao  = ao;
        e.sn  = sn;
        e.su  = su;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        vectors++;
        assert (alarm_on === got.ao && snoozing === got.sn && snooze_used === got.su)
        else begin
            miscompares++;
            $error("FAIL %s: got alarm_on=%b snoozing=%b snooze_used=%0d, expected %b %b %0d",
                   got.tag, alarm_on, snoozing, snooze_used, got.ao, got.sn, got.su);
        end
        tick_1hz   = 1'b0;
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
    endtask

    task automatic set_time(input int h, input int m);
        cur_hour = 5'(h);
        cur_min  = 6'(m);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        tick_1hz    = 1'b0;
        stop_btn    = 1'b0;
        snooze_btn  = 1'b0;
        alarm_en    = 1'b1;
        alm_hour    = 5'd7;
        alm_min     = 6'd30;
        set_time(7, 29);

        apply("reset", 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        apply("idle_before_match", 1'b0, 1'b0, 2'd0);

        // Basic trigger and auto-stop after 5 ticks
        set_time(7, 30);
        apply("trigger_0730", 1'b1, 1'b0, 2'd0);
        apply("ring_no_tick", 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            tick_1hz = 1'b1;
            apply("ring_tick", 1'b1, 1'b0, 2'd0);
        end
        tick_1hz = 1'b1;
        apply("ring_timeout", 1'b0, 1'b0, 2'd0);
        apply("no_retrigger_held", 1'b0, 1'b0, 2'd0);

        // Snooze and return to ringing after 3 ticks
        set_time(7, 31);
        apply("idle_0731", 1'b0, 1'b0, 2'd0);
        set_time(7, 30);
        apply("retrigger", 1'b1, 1'b0, 2'd0);
        snooze_btn = 1'b1;
        apply("snooze1", 1'b0, 1'b1, 2'd1);
        for (int i = 0; i < 2; i++) begin
            tick_1hz = 1'b1;
            apply("snooze_tick", 1'b0, 1'b1, 2'd1);
        end
        apply("snooze_no_tick", 1'b0, 1'b1, 2'd1);
        tick_1hz = 1'b1;
        apply("snooze1_expire", 1'b1, 1'b0, 2'd1);

        // Second snooze, then third press acts as stop
        snooze_btn = 1'b1;
        apply("snooze2", 1'b0, 1'b1, 2'd2);
        for (int i = 0; i < 2; i++) begin
            tick_1hz = 1'b1;
            apply("snooze2_tick", 1'b0, 1'b1, 2'd2);
        end
        tick_1hz = 1'b1;
        apply("snooze2_expire", 1'b1, 1'b0, 2'd2);
        snooze_btn = 1'b1;
        apply("snooze_exhausted", 1'b0, 1'b0, 2'd2);
        apply("used_held_idle", 1'b0, 1'b0, 2'd2);
        set_time(7, 31);
        apply("idle_used_kept", 1'b0, 1'b0, 2'd2);
        set_time(7, 30);
        apply("trigger_clears_used", 1'b1, 1'b0, 2'd0);

        // stop beats snooze
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        apply("stop_over_snooze", 1'b0, 1'b0, 2'd0);

        // snooze beats tick expiry on last ring second
        set_time(7, 31);
        apply("idle_0731_b", 1'b0, 1'b0, 2'd0);
        set_time(7, 30);
        apply("retrigger_b", 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            tick_1hz = 1'b1;
            apply("ring_tick_b", 1'b1, 1'b0, 2'd0);
        end
        tick_1hz   = 1'b1;
        snooze_btn = 1'b1;
        apply("snooze_over_expiry", 1'b0, 1'b1, 2'd1);
        stop_btn = 1'b1;
        apply("stop_in_snooze", 1'b0, 1'b0, 2'd1);

        // Reset mid-ring with time held at alarm time
        set_time(7, 31);
        apply("idle_0731_c", 1'b0, 1'b0, 2'd1);
        set_time(7, 30);
        apply("retrigger_c", 1'b1, 1'b0, 2'd0);
        rst_n = 1'b0;
        #1;
        vectors++;
        assert (alarm_on === 1'b0)
        else begin
            miscompares++;
            $error("FAIL async_reset: got alarm_on=%b, expected 0", alarm_on);
        end
        apply("reset_held", 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        apply("release_no_trigger", 1'b0, 1'b0, 2'd0);
        apply("release_no_trigger2", 1'b0, 1'b0, 2'd0);

        // Disarm mid-snooze, then re-arm while match already high
        set_time(7, 31);
        apply("idle_0731_d", 1'b0, 1'b0, 2'd0);
        set_time(7, 30);
        apply("retrigger_d", 1'b1, 1'b0, 2'd0);
        snooze_btn = 1'b1;
        apply("snooze_d", 1'b0, 1'b1, 2'd1);
        alarm_en = 1'b0;
        apply("disarm_in_snooze", 1'b0, 1'b0, 2'd1);
        alarm_en = 1'b1;
        apply("arm_while_match", 1'b0, 1'b0, 2'd1);

        // Moving alarm onto the current time triggers
        set_time(8, 0);
        apply("time_0800", 1'b0, 1'b0, 2'd1);
        alm_hour = 5'd8;
        alm_min  = 6'd0;
        apply("alarm_set_to_now", 1'b1, 1'b0, 2'd0);
        alarm_en = 1'b0;
        stop_btn = 1'b0;
        snooze_btn = 1'b1;
        apply("disarm_over_snooze", 1'b0, 1'b0, 2'd0);
        alarm_en = 1'b1;

        // Midnight rollover while ringing
        alm_hour = 5'd23;
        alm_min  = 6'd59;
        set_time(23, 58);
        apply("time_2358", 1'b0, 1'b0, 2'd0);
        set_time(23, 59);
        apply("trigger_2359", 1'b1, 1'b0, 2'd0);
        tick_1hz = 1'b1;
        apply("midnight_tick1", 1'b1, 1'b0, 2'd0);
        set_time(0, 0);
        tick_1hz = 1'b1;
        apply("midnight_tick2", 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 2; i++) begin
            tick_1hz = 1'b1;
            apply("midnight_tick", 1'b1, 1'b0, 2'd0);
        end
        tick_1hz = 1'b1;
        apply("midnight_timeout", 1'b0, 1'b0, 2'd0);
        apply("midnight_idle", 1'b0, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter RING_SECONDS, default 60, meaning: max ring duration in tick_1hz pulses before auto-stop.
REQ-002 Parameter SNOOZE_SECONDS, default 300, meaning: snooze interval in tick_1hz pulses.
REQ-003 Parameter MAX_SNOOZE, default 3, meaning: snoozes allowed per alarm event; further snooze presses act as stop.
REQ-004 clk  input  1  50 MHz system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 tick_1hz  input  1  one-clk-wide pulse once per second, clk-synchronous.
REQ-007 cur_hour  input  5  current hour, 0..23.
REQ-008 cur_min  input  6  current minute, 0..59.
REQ-009 alm_hour  input  5  alarm hour, 0..23.
REQ-010 alm_min  input  6  alarm minute, 0..59.
REQ-011 alarm_en  input  1  alarm armed level.
REQ-012 stop_btn  input  1  debounced one-clk pulse: cancel alarm event.
REQ-013 snooze_btn  input  1  debounced one-clk pulse: snooze.
REQ-014 alarm_on  output  1  registered level driving the buzzer stage's alarm_on input; high only in RINGING.
REQ-015 snoozing  output  1  registered level, high only in SNOOZE.
REQ-016 snooze_used  output  2  registered count of snoozes taken in current event.

Function
REQ-017 match SHALL be (cur_hour==alm_hour) && (cur_min==alm_min); match_q SHALL be match registered each clk.
REQ-018 trigger SHALL be match && !match_q && alarm_en, evaluated every clk; seconds not compared.
REQ-019 States SHALL be IDLE, RINGING, SNOOZE.
REQ-020 IDLE: trigger -> RINGING, ring_cnt=0, snooze_used=0.
REQ-021 RINGING: each tick_1hz increments ring_cnt; tick with ring_cnt==RING_SECONDS-1 -> IDLE.
REQ-022 RINGING: stop_btn -> IDLE; snooze_btn with snooze_used<MAX_SNOOZE -> SNOOZE, snz_cnt=SNOOZE_SECONDS, snooze_used+1; snooze_btn with snooze_used==MAX_SNOOZE -> IDLE.
REQ-023 SNOOZE: each tick_1hz decrements snz_cnt; tick with snz_cnt==1 -> RINGING, ring_cnt=0; stop_btn -> IDLE.
REQ-024 alarm_en low in any state SHALL force IDLE on the next edge, overriding all other events.
REQ-025 Priority on simultaneous events: alarm_en low > stop_btn > snooze_btn > tick_1hz expiry.
REQ-026 trigger in RINGING or SNOOZE SHALL be ignored.
REQ-027 alarm_on/snoozing SHALL update on the same edge as the state register: high in the cycle after the causing condition is sampled (latency 1 clk).
REQ-028 Enabling alarm_en while match already high SHALL NOT trigger (no rising edge); setting alm_* to the current time while enabled SHALL trigger.
REQ-029 ring_cnt width ceil(log2(RING_SECONDS+1)); snz_cnt width ceil(log2(SNOOZE_SECONDS+1)); no wrap-around possible.
REQ-030 Midnight rollover (23:59->00:00) SHALL be handled by REQ-017 alone; no special case.

Reset
REQ-031 rst_n low SHALL asynchronously force state=IDLE, alarm_on=0, snoozing=0, snooze_used=0, ring_cnt=0, snz_cnt=0, match_q=1.
REQ-032 match_q reset to 1 SHALL prevent a trigger on reset release when time already equals alarm time.
REQ-033 Reset mid-RINGING or mid-SNOOZE SHALL abandon the event; no resumption after release.

Structure
REQ-034 State encoding and hour/minute field widths SHALL live in the shared clock definitions package; timing parameters stay local to the module.
REQ-035 One sub-module, alarm_time_match, SHALL contain the comparator and match_q edge register, outputting trigger.
REQ-036 Single always block per register group; no gated or derived clocks; tick_1hz used as enable only.

Verification (bench parameters: RING_SECONDS=5, SNOOZE_SECONDS=3, MAX_SNOOZE=2)
REQ-037 alm=07:30, en=1, time steps 07:29->07:30 -> alarm_on=1 one clk later; after 5 ticks alarm_on=0, state IDLE.
REQ-038 Ringing, snooze_btn -> snoozing=1, alarm_on=0, snooze_used=1; after 3 ticks alarm_on=1 again.
REQ-039 Two snoozes taken, ringing, third snooze_btn -> IDLE, alarm_on=0, snooze_used stays 2 until next trigger clears it.
REQ-040 stop_btn and snooze_btn same clk while ringing -> IDLE, snoozing=0; tick and snooze same clk on last ring second -> SNOOZE.
REQ-041 Time held at 07:30, rst_n pulsed low then released -> alarm_on stays 0; alarm_en 0 mid-SNOOZE -> IDLE next clk.
REQ-042 alm=23:59, time 23:59->00:00 while ringing -> ringing continues, no retrigger, timeout after 5 ticks.
